// File: rtl/mxu_seq_ctrl.sv
// mxu_seq_ctrl: phase sequencer (load, compute/skew flush, accumulate drain) for the SIZE x SIZE systolic array.
// Optional busy-cycle counter enabled by defining MXU_SEQ_PERF_EN.
module mxu_seq_ctrl #(
    parameter int SIZE = 16,
    localparam int RW = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          stall,
    output logic          busy,
    output logic          done,
    output logic          load_en,
    output logic          mult_en,
    output logic          acc_en,
    output logic          rd_en,
    output logic          rd_bank,
    output logic [RW-1:0] rd_row,
    output logic [RW-1:0] acc_row,
    output logic [31:0]   perf_cycles
);
    localparam int CW = RW + 2;
    localparam logic [CW-1:0] EDGE_END = CW'(SIZE - 1);
    localparam logic [CW-1:0] COMP_END = CW'(3 * SIZE - 3);
    localparam logic [CW-1:0] SIZE_CW  = CW'(SIZE);

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, ACC, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CW'(1);
        case (state)
            IDLE:    begin cnt_nx = '0; state_nx = (start && !abort) ? LOAD : IDLE; end
            LOAD:    if (cnt == EDGE_END) begin state_nx = COMPUTE; cnt_nx = '0; end
            COMPUTE: if (cnt == COMP_END) begin state_nx = ACC; cnt_nx = '0; end
            ACC:     if (cnt == EDGE_END) begin state_nx = DONE; cnt_nx = '0; end
            default: begin state_nx = IDLE; cnt_nx = '0; end
        endcase
        // stall freezes only the working phases; abort outranks both stall and phase ends
        if (stall && (state == LOAD || state == COMPUTE || state == ACC)) begin
            state_nx = state;
            cnt_nx   = cnt;
        end
        if (abort && state != IDLE) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end
        busy    = state != IDLE;
        done    = state == DONE;
        load_en = state == LOAD && !stall;
        rd_bank = load_en;
        mult_en = state == COMPUTE && !stall;
        acc_en  = state == ACC && !stall;
        rd_en   = (state == LOAD || (state == COMPUTE && cnt < SIZE_CW)) && !stall;
        rd_row  = rd_en ? cnt[RW-1:0] : '0;
        acc_row = acc_en ? cnt[RW-1:0] : '0;
    end

`ifdef MXU_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset)
            perf_cycles <= '0;
        else if (state == IDLE && start && !abort)
            perf_cycles <= '0;
        else if (busy && perf_cycles != 32'hFFFF_FFFF)
            perf_cycles <= perf_cycles + 32'd1;
    end
`else
    assign perf_cycles = 32'h0;
`endif
endmodule

// File: tb/tb_mxu_seq_ctrl.sv
// tb_mxu_seq_ctrl: directed scoreboard bench for mxu_seq_ctrl at SIZE=4.
// Expected outputs come from a cycle-position timeline of the operation, not from the DUT.
module tb_mxu_seq_ctrl;
    localparam int S = 4;
    localparam int RW = $clog2(S);

    logic clk, reset, start, abort, stall;
    logic busy, done, load_en, mult_en, acc_en, rd_en, rd_bank;
    logic [RW-1:0] rd_row, acc_row;
    logic [31:0] perf_cycles;

    mxu_seq_ctrl #(.SIZE(S)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .stall(stall),
        .busy(busy), .done(done), .load_en(load_en), .mult_en(mult_en), .acc_en(acc_en),
        .rd_en(rd_en), .rd_bank(rd_bank), .rd_row(rd_row), .acc_row(acc_row),
        .perf_cycles(perf_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [7+2*RW+32-1:0] vec_t;
    vec_t sb[$];
    int checks = 0;
    int errors = 0;
    bit active = 0;
    int pos = 0;
    logic [31:0] perf_m = '0;

    // position 0..5S-2 within an operation: LOAD, COMPUTE (reads in first S), ACC, DONE
    function automatic vec_t expv(bit act, int p, bit stl, logic [31:0] pf);
        logic b, d, l, m, a, r, bk;
        logic [RW-1:0] rr, ar;
        {b, d, l, m, a, r, bk, rr, ar} = '0;
        if (act) begin
            b = 1'b1;
            if (p == 5*S-2) d = 1'b1;
            else if (!stl) begin
                if (p < S) begin l = 1'b1; r = 1'b1; bk = 1'b1; rr = RW'(p); end
                else if (p < 4*S-2) begin
                    m = 1'b1;
                    if (p < 2*S) begin r = 1'b1; rr = RW'(p - S); end
                end else begin a = 1'b1; ar = RW'(p - (4*S-2)); end
            end
        end
`ifdef MXU_SEQ_PERF_EN
        return {b, d, l, m, a, r, bk, rr, ar, pf};
`else
        return {b, d, l, m, a, r, bk, rr, ar, 32'h0};
`endif
    endfunction

    task automatic cyc(input string tag, input int c, input logic s, input logic a, input logic st, input logic r);
        vec_t got, exp;
        @(posedge clk);
        #1;
        start = s; abort = a; stall = st; reset = r;
        sb.push_back(expv(active, pos, st, perf_m));
        @(negedge clk);
        got = {busy, done, load_en, mult_en, acc_en, rd_en, rd_bank, rd_row, acc_row, perf_cycles};
        exp = sb.pop_front();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc %0d got %h exp %h", tag, c, got, exp);
        end
        if (r) begin active = 0; pos = 0; perf_m = '0; end
        else if (active) begin
            perf_m++;
            if (a) active = 0;
            else if (pos == 5*S-2) active = 0;
            else if (!st) pos++;
        end else if (s && !a) begin active = 1; pos = 0; perf_m = '0; end
    endtask

    initial begin
        {start, abort, stall} = '0;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) cyc("reset", c, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) cyc("idle", c, 1'b0, 1'b0, c == 1, 1'b0);
        for (int c = 0; c < 25; c++) cyc("nominal", c, c == 0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 25; c++) cyc("stall", c, c == 0, 1'b0, c == 3 || c == 9, 1'b0);
        for (int c = 0; c < 33; c++) cyc("abort", c, c == 0 || c == 10, c == 7, 1'b0, 1'b0);
        for (int c = 0; c < 45; c++) cyc("start_busy", c, c <= 25, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 40; c++) cyc("reset_mid", c, c == 0, 1'b0, 1'b0, c == 8);
        for (int c = 0; c < 45; c++) cyc("edge_stall", c, c == 0 || c == 21, 1'b0, c == 19 || c == 21 || c == 20, 1'b0);
        for (int c = 0; c < 8; c++) cyc("abort_idle", c, c == 1, c == 1 || c == 2, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) cyc("abort_phase_end", c, c == 0, c == 4, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) cyc("abort_stall", c, c == 0, c == 6, c >= 5, 1'b0);
        for (int c = 0; c < 28; c++) cyc("long_stall", c, c == 0, 1'b0, c >= 14 && c < 17, 1'b0);
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_empty got %0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
